l1_wb_buffer: RTL and testbench
===============================

L1_WB_BUFFER -- requirements
Module: l1_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the write-buffer entry count (power of 2, at least 2).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the address and data width.
REQ-003 Reset: one clock; reset is synchronous and active-high, on ports clk and rst.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_request  in  1  cache request, level-held until mem_ready
- mem_write_enable  in  1  1=write (writeback), 0=read (fill)
- mem_address  in  32  word address
- mem_write_data  in  32  write data
- mem_response_data  out  32  read data, valid when mem_ready=1
- mem_ready  out  1  single-cycle completion pulse
- bus_req  out  1  main-memory request, held until bus_ack
- bus_we  out  1  bus write
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data, valid with bus_ack
- bus_ack  in  1  single-cycle bus completion
- buf_count  out  $clog2(DEPTH)+1  occupied entries
- buf_empty  out  1  buf_count==0

Function
REQ-005 The block SHALL hold a FIFO of DEPTH {addr,data} entries between the cache and main memory.
REQ-006 Write accept: with mem_request=1, mem_write_enable=1, no match and not full, the block SHALL enqueue the entry and pulse mem_ready on the next cycle.
REQ-007 Write coalesce: if mem_address equals a valid entry's address, the block SHALL overwrite that entry's data in place, with no count change, and pulse mem_ready next cycle, even when full.
REQ-008 A full buffer with no match SHALL stall the write, with mem_ready=0, until a drain frees a slot; the write is accepted in the cycle the slot is freed and mem_ready follows next cycle.
REQ-009 Read forward: on a read whose address matches a valid entry, the block SHALL return that entry's data with mem_ready on the next cycle, without a bus access.
REQ-010 Read miss: the block SHALL issue bus_req with bus_we=0 and bus_addr=mem_address once the bus is idle; on bus_ack it SHALL register bus_rdata and pulse mem_ready with it on the following cycle.
REQ-011 Bus priority: a pending read miss SHALL win over draining; otherwise, when the buffer is non-empty and the bus is idle, the block SHALL issue the head entry as a write (bus_we=1).
REQ-012 bus_req, bus_we, bus_addr and bus_wdata SHALL remain stable from assertion until the bus_ack cycle, and bus_req SHALL drop in the cycle after bus_ack.
REQ-013 At most one bus transaction SHALL be outstanding; the drain FSM states are BUS_IDLE, BUS_WR, BUS_RD.
REQ-014 The cache FSM states SHALL be IDLE, ACCEPT, RD_WAIT, RESP and GUARD:
- IDLE to ACCEPT on a write that can be taken, or on a read hit.
- IDLE to RD_WAIT on a read miss.
- RD_WAIT to RESP on bus_ack.
- ACCEPT and RESP drive mem_ready for one cycle, then go to GUARD.
- GUARD ignores mem_request for exactly one cycle, because the cache deasserts its request one cycle late, then returns to IDLE.
REQ-015 A drain completing (bus_ack in BUS_WR) in the same cycle as a write accept SHALL pop the head and push the new entry, leaving count unchanged.
REQ-016 A coalesce that targets the head entry while it is on the bus SHALL be treated as a non-match and enqueue a new entry.
REQ-017 Head and tail pointers SHALL wrap modulo DEPTH, and buf_count SHALL never exceed DEPTH.
REQ-018 mem_ready SHALL never be asserted on two consecutive cycles.

Reset
REQ-019 When rst=1 at a clk edge, the block SHALL clear all entries, pointers and the count, and put both FSMs in IDLE/BUS_IDLE.
REQ-020 Reset output values SHALL be: mem_ready=0, mem_response_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, buf_count=0, buf_empty=1.
REQ-021 A reset during an outstanding bus transaction SHALL abandon it, and a bus_ack arriving after reset SHALL be ignored.

Verification
REQ-022 Write 0x100 with data 0xAAAA, bus_ack held low -> mem_ready pulses one cycle later, buf_count=1, bus_req=1 with bus_we=1, bus_addr=0x100, bus_wdata=0xAAAA.
REQ-023 Write 0x100/0x1111, then 0x100/0x2222 before any drain -> buf_count stays 1, and the drained bus_wdata=0x2222.
REQ-024 Fill all 4 entries with bus_ack held low, then issue a fifth write -> mem_ready stays low; after one bus_ack the write is accepted, buf_count=4 and mem_ready pulses next cycle.
REQ-025 Write 0x200/0xBEEF still buffered, then read 0x200 -> mem_response_data=0xBEEF with mem_ready next cycle, and no bus_we=0 request is issued.
REQ-026 Read 0x300 while 0x100 is buffered, bus idle -> a bus read for 0x300 is issued before the drain; bus_ack with bus_rdata=0x1234 gives mem_response_data=0x1234 with mem_ready on the next cycle.
REQ-027 Assert rst while bus_req=1 in BUS_WR -> all outputs take their reset values next cycle, and a late bus_ack does not change buf_count.

Source files
------------

// File: rtl/l1_wb_buffer.sv
// rtl/l1_wb_buffer.sv - L1 write buffer with coalescing, read forwarding and a single-outstanding bus drain
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   mem_*              cache side: level-held request, single-cycle mem_ready completion
//   bus_*              main-memory side: bus_req held until the single-cycle bus_ack
//   buf_count          occupied entries (0..DEPTH)
//   buf_empty          buf_count == 0
module l1_wb_buffer #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_request,
  input  logic                    mem_write_enable,
  input  logic [DATA_WIDTH-1:0]   mem_address,
  input  logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic [DATA_WIDTH-1:0]   mem_response_data,
  output logic                    mem_ready,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [DATA_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_ack,
  output logic [$clog2(DEPTH):0]  buf_count,
  output logic                    buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, ACCEPT, RD_WAIT, RESP, GUARD} cache_state_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_WR, BUS_RD} bus_state_t;

  cache_state_t cache_state_q, cache_state_d;
  bus_state_t   bus_state_q, bus_state_d;

  logic [DATA_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;

  logic [DATA_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  bus_req_q;
  logic                  bus_we_q;
  logic [DATA_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;

  logic                  drain_done;
  logic                  read_done;
  logic                  issue_read;
  logic                  issue_drain;
  logic                  head_busy;
  logic                  is_full;
  logic                  wr_req;
  logic                  rd_req;
  logic                  match_nb;
  logic [PW-1:0]         match_idx;
  logic                  head_hit;
  logic                  do_coalesce;
  logic                  do_push;
  logic                  rd_hit;
  logic                  rd_miss;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign drain_done  = (bus_state_q == BUS_WR) && bus_ack;
  assign read_done   = (bus_state_q == BUS_RD) && bus_ack;
  // A waiting read miss always takes the idle bus ahead of draining.
  assign issue_read  = (bus_state_q == BUS_IDLE) && (cache_state_q == RD_WAIT);
  assign issue_drain = (bus_state_q == BUS_IDLE) && !issue_read && (count_q != '0);
  // The head is frozen from the cycle its drain is launched: its data has
  // already been (or is being) copied into bus_wdata, so it must not coalesce.
  assign head_busy   = (bus_state_q == BUS_WR) || issue_drain;
  assign is_full     = (count_q == FULL_COUNT);

  assign wr_req = (cache_state_q == IDLE) && mem_request && mem_write_enable;
  assign rd_req = (cache_state_q == IDLE) && mem_request && !mem_write_enable;

  // Address match. A frozen head only counts as a read hit; writes to it
  // allocate a fresh entry. Duplicates therefore exist only as
  // (frozen head, one younger entry), and the younger one is preferred.
  always_comb begin
    match_nb  = 1'b0;
    match_idx = '0;
    head_hit  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == mem_address)) begin
        if (head_busy && (PW'(i) == head_q)) begin
          head_hit = 1'b1;
        end else begin
          match_nb  = 1'b1;
          match_idx = PW'(i);
        end
      end
    end
  end

  assign do_coalesce = wr_req && match_nb;
  // A full buffer still accepts when the head drains in the same cycle.
  assign do_push     = wr_req && !match_nb && (!is_full || drain_done);
  assign rd_hit      = rd_req && (match_nb || head_hit);
  assign rd_miss     = rd_req && !rd_hit;
  assign fwd_data    = match_nb ? data_q[match_idx] : data_q[head_q];

  // Cache-side FSM
  always_comb begin
    cache_state_d = cache_state_q;
    mem_ready     = 1'b0;
    case (cache_state_q)
      IDLE: begin
        if (do_coalesce || do_push || rd_hit) begin
          cache_state_d = ACCEPT;
        end else if (rd_miss) begin
          cache_state_d = RD_WAIT;
        end
      end
      ACCEPT: begin
        mem_ready     = 1'b1;
        cache_state_d = GUARD;
      end
      RD_WAIT: begin
        if (read_done) begin
          cache_state_d = RESP;
        end
      end
      RESP: begin
        mem_ready     = 1'b1;
        cache_state_d = GUARD;
      end
      // The cache drops its request one cycle after mem_ready; skip that cycle.
      GUARD: begin
        cache_state_d = IDLE;
      end
      default: begin
        cache_state_d = IDLE;
      end
    endcase
  end

  // Bus-side FSM
  always_comb begin
    bus_state_d = bus_state_q;
    case (bus_state_q)
      BUS_IDLE: begin
        if (issue_read) begin
          bus_state_d = BUS_RD;
        end else if (issue_drain) begin
          bus_state_d = BUS_WR;
        end
      end
      BUS_WR: begin
        if (bus_ack) begin
          bus_state_d = BUS_IDLE;
        end
      end
      BUS_RD: begin
        if (bus_ack) begin
          bus_state_d = BUS_IDLE;
        end
      end
      default: begin
        bus_state_d = BUS_IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (do_push && !drain_done) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && drain_done) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_state_q <= IDLE;
      bus_state_q   <= BUS_IDLE;
    end else begin
      cache_state_q <= cache_state_d;
      bus_state_q   <= bus_state_d;
    end
  end

  // Entry storage. Pop is applied before push so a push into the slot being
  // freed (full buffer, tail == head) leaves it valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (drain_done) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (do_push) begin
        addr_q[tail_q]  <= mem_address;
        data_q[tail_q]  <= mem_write_data;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (do_coalesce) begin
        data_q[match_idx] <= mem_write_data;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q   <= '0;
      resp_data_q <= '0;
    end else begin
      if (rd_miss) begin
        rd_addr_q <= mem_address;
      end
      if (rd_hit) begin
        resp_data_q <= fwd_data;
      end else if (read_done) begin
        resp_data_q <= bus_rdata;
      end
    end
  end

  // Bus request registers: loaded at launch, held until the ack cycle,
  // cleared the cycle after.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else if (issue_read) begin
      bus_req_q   <= 1'b1;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= rd_addr_q;
      bus_wdata_q <= '0;
    end else if (issue_drain) begin
      bus_req_q   <= 1'b1;
      bus_we_q    <= 1'b1;
      bus_addr_q  <= addr_q[head_q];
      bus_wdata_q <= data_q[head_q];
    end else if (drain_done || read_done) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end
  end

  assign mem_response_data = resp_data_q;
  assign bus_req           = bus_req_q;
  assign bus_we            = bus_we_q;
  assign bus_addr          = bus_addr_q;
  assign bus_wdata         = bus_wdata_q;
  assign buf_count         = count_q;
  assign buf_empty         = (count_q == '0);

endmodule

// File: tb/tb_l1_wb_buffer.sv
// tb/tb_l1_wb_buffer.sv - directed self-checking bench for l1_wb_buffer
module tb_l1_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_request;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_response_data;
  logic        mem_ready;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [2:0]  buf_count;
  logic        buf_empty;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  logic stalled;

  always #5 clk = ~clk;

  l1_wb_buffer #(.DEPTH(4), .DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_request       (mem_request),
    .mem_write_enable  (mem_write_enable),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_response_data (mem_response_data),
    .mem_ready         (mem_ready),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_rdata         (bus_rdata),
    .bus_ack           (bus_ack),
    .buf_count         (buf_count),
    .buf_empty         (buf_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until mem_ready (bounded) and return the cycle count.
  task automatic cache_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int cycles);
    mem_request      = 1'b1;
    mem_write_enable = we;
    mem_address      = a;
    mem_write_data   = d;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!mem_ready && cycles < 8);
    mem_request = 1'b0;
  endtask

  task automatic pulse_ack(input logic [31:0] rdata);
    bus_rdata = rdata;
    bus_ack   = 1'b1;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
  endtask

  task automatic drain_all(input string tag);
    int guard_cnt = 0;
    while (buf_count != 0 && guard_cnt < 40) begin
      if (bus_req) pulse_ack('0);
      else step();
      guard_cnt++;
    end
    check(tag, 32'(buf_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_request = 1'b0; mem_write_enable = 1'b0;
    mem_address = '0; mem_write_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    step();
    step();
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_resp",      mem_response_data, 32'd0);
    check("rst_bus_req",   32'(bus_req), 32'd0);
    check("rst_bus_we",    32'(bus_we), 32'd0);
    check("rst_bus_addr",  bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_count",     32'(buf_count), 32'd0);
    check("rst_empty",     32'(buf_empty), 32'd1);
    rst = 1'b0;

    // Single write, drain launched with ack held low
    cache_op(1'b1, 32'h100, 32'hAAAA, lat);
    check("wr_lat",   32'(lat), 32'd1);
    check("wr_count", 32'(buf_count), 32'd1);
    step();
    check("wr_ready_single", 32'(mem_ready), 32'd0);
    step();
    check("wr_bus_req",   32'(bus_req), 32'd1);
    check("wr_bus_we",    32'(bus_we), 32'd1);
    check("wr_bus_addr",  bus_addr, 32'h100);
    check("wr_bus_wdata", bus_wdata, 32'hAAAA);
    pulse_ack('0);
    check("wr_bus_drop", 32'(bus_req), 32'd0);
    check("wr_drained",  32'(buf_count), 32'd0);
    check("wr_empty",    32'(buf_empty), 32'd1);

    // Coalesce: 0x080 occupies the bus so both 0x100 writes land before its drain
    cache_op(1'b1, 32'h080, 32'h5555, lat);
    step(); step();
    check("co_busy_addr", bus_addr, 32'h080);
    cache_op(1'b1, 32'h100, 32'h1111, lat);
    step(); step();
    check("co_count_a", 32'(buf_count), 32'd2);
    cache_op(1'b1, 32'h100, 32'h2222, lat);
    check("co_lat",     32'(lat), 32'd1);
    check("co_count_b", 32'(buf_count), 32'd2);
    step(); step();
    pulse_ack('0);
    check("co_count_c", 32'(buf_count), 32'd1);
    step();
    check("co_bus_req",   32'(bus_req), 32'd1);
    check("co_bus_addr",  bus_addr, 32'h100);
    check("co_bus_wdata", bus_wdata, 32'h2222);
    pulse_ack('0);
    check("co_drained", 32'(buf_count), 32'd0);

    // Full buffer stall, accepted in the cycle a drain frees a slot
    for (int i = 0; i < 4; i++) begin
      cache_op(1'b1, 32'h400 + 32'(i), 32'h10 + 32'(i), lat);
      check("fill_lat", 32'(lat), 32'd1);
      step(); step();
    end
    check("fill_count", 32'(buf_count), 32'd4);
    mem_request = 1'b1; mem_write_enable = 1'b1;
    mem_address = 32'h404; mem_write_data = 32'h14;
    stalled = 1'b0;
    repeat (3) begin
      step();
      if (mem_ready) stalled = 1'b1;
    end
    check("full_stall",       32'(stalled), 32'd0);
    check("full_stall_count", 32'(buf_count), 32'd4);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("full_accept_ready", 32'(mem_ready), 32'd1);
    check("full_accept_count", 32'(buf_count), 32'd4);
    mem_request = 1'b0;
    step();
    check("full_next_req",  32'(bus_req), 32'd1);
    check("full_next_addr", bus_addr, 32'h401);
    step();
    drain_all("full_drained");

    // Read forward from a buffered entry (its drain is on the bus)
    cache_op(1'b1, 32'h200, 32'hBEEF, lat);
    step(); step();
    cache_op(1'b0, 32'h200, 32'h0, lat);
    check("fwd_lat",  32'(lat), 32'd1);
    check("fwd_data", mem_response_data, 32'hBEEF);
    step(); step();
    check("fwd_no_rd_we",  32'(bus_we), 32'd1);
    check("fwd_no_rd_addr", bus_addr, 32'h200);
    pulse_ack('0);
    check("fwd_drained", 32'(buf_count), 32'd0);

    // Read miss wins the bus over the buffered 0x100 entry
    cache_op(1'b1, 32'h080, 32'h1, lat);
    step(); step();
    cache_op(1'b1, 32'h100, 32'h2, lat);
    step(); step();
    check("rm_count", 32'(buf_count), 32'd2);
    mem_request = 1'b1; mem_write_enable = 1'b0; mem_address = 32'h300;
    step();
    check("rm_no_ready", 32'(mem_ready), 32'd0);
    pulse_ack('0);
    check("rm_count_b", 32'(buf_count), 32'd1);
    step();
    check("rm_bus_req",  32'(bus_req), 32'd1);
    check("rm_bus_we",   32'(bus_we), 32'd0);
    check("rm_bus_addr", bus_addr, 32'h300);
    bus_rdata = 32'h1234;
    bus_ack   = 1'b1;
    step();
    bus_ack   = 1'b0;
    bus_rdata = '0;
    check("rm_ready", 32'(mem_ready), 32'd1);
    check("rm_data",  mem_response_data, 32'h1234);
    mem_request = 1'b0;
    step();
    check("rm_ready_single", 32'(mem_ready), 32'd0);
    check("rm_drain_we",     32'(bus_we), 32'd1);
    check("rm_drain_addr",   bus_addr, 32'h100);
    step();
    pulse_ack('0);
    check("rm_drained", 32'(buf_count), 32'd0);

    // Reset with a drain outstanding; a late ack is ignored
    cache_op(1'b1, 32'h500, 32'h77, lat);
    step(); step();
    check("rb_pre_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    step();
    check("rb_mem_ready", 32'(mem_ready), 32'd0);
    check("rb_resp",      mem_response_data, 32'd0);
    check("rb_bus_req",   32'(bus_req), 32'd0);
    check("rb_bus_we",    32'(bus_we), 32'd0);
    check("rb_bus_addr",  bus_addr, 32'd0);
    check("rb_bus_wdata", bus_wdata, 32'd0);
    check("rb_count",     32'(buf_count), 32'd0);
    check("rb_empty",     32'(buf_empty), 32'd1);
    rst = 1'b0;
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("rb_late_ack_count", 32'(buf_count), 32'd0);
    step();
    check("rb_late_ack_req", 32'(bus_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
